// File: rtl/keypad_operand_entry.sv
// Keypad operand entry: decodes PS/2 make codes into a two-operand BCD
// expression (A op B) and hands it to the calculator datapath on Enter.
module keypad_operand_entry #(
    parameter int DIGITS = 4,
    parameter int SCAN_W = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         key_valid,
    input  logic [SCAN_W-1:0]            last_change,
    output logic [4*DIGITS-1:0]          disp_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  digit_cnt,
    output logic [4*DIGITS-1:0]          operand_a,
    output logic [4*DIGITS-1:0]          operand_b,
    output logic [1:0]                   op,
    output logic [1:0]                   phase,
    output logic                         go,
    output logic                         err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

    typedef enum logic [1:0] {
        ENTER_A = 2'd0,
        ENTER_B = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        K_NONE, K_DIGIT, K_OP, K_ENTER, K_BKSP, K_ESC
    } key_t;

    function automatic key_t key_class(input logic [8:0] code);
        case (code)
            9'h070, 9'h069, 9'h072, 9'h07A, 9'h06B,
            9'h073, 9'h074, 9'h06C, 9'h075, 9'h07D: key_class = K_DIGIT;
            9'h079, 9'h07B, 9'h03A:                 key_class = K_OP;
            9'h15A, 9'h05A:                         key_class = K_ENTER;
            9'h066:                                 key_class = K_BKSP;
            9'h076:                                 key_class = K_ESC;
            default:                                key_class = K_NONE;
        endcase
    endfunction

    function automatic logic [3:0] digit_val(input logic [8:0] code);
        case (code)
            9'h069:  digit_val = 4'd1;
            9'h072:  digit_val = 4'd2;
            9'h07A:  digit_val = 4'd3;
            9'h06B:  digit_val = 4'd4;
            9'h073:  digit_val = 4'd5;
            9'h074:  digit_val = 4'd6;
            9'h06C:  digit_val = 4'd7;
            9'h075:  digit_val = 4'd8;
            9'h07D:  digit_val = 4'd9;
            default: digit_val = 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] op_val(input logic [8:0] code);
        case (code)
            9'h07B:  op_val = 2'd1;
            9'h03A:  op_val = 2'd2;
            default: op_val = 2'd0;
        endcase
    endfunction

    state_t          state, state_d;
    logic [BW-1:0]   buffer, buffer_d;
    logic [CW-1:0]   cnt_d;
    logic [BW-1:0]   operand_a_d, operand_b_d;
    logic [1:0]      op_d;
    logic            go_d, err_d;

    logic [8:0]      code;
    key_t            kind;
    logic            has_digits, full;
    logic            do_esc, do_bksp, do_shift, do_restart;
    logic            take_a, swap_op, take_b, reject;

    assign code = last_change[8:0];
    assign kind = key_valid ? key_class(code) : K_NONE;

    assign has_digits = (digit_cnt != '0);
    assign full       = (digit_cnt == CNT_FULL);

    // Every accepted or rejected action is decided here once; the next-state
    // and datapath processes only consume these flags.
    assign do_esc     = (kind == K_ESC);
    assign do_bksp    = (kind == K_BKSP) && has_digits;
    assign do_shift   = (kind == K_DIGIT) && (state != DONE) && !full;
    assign do_restart = (kind == K_DIGIT) && (state == DONE);
    assign take_a     = (kind == K_OP) && (state == ENTER_A) && has_digits;
    assign swap_op    = (kind == K_OP) && (state == ENTER_B) && !has_digits;
    assign take_b     = (kind == K_ENTER) && (state == ENTER_B) && has_digits;
    assign reject     = ((kind == K_DIGIT) && (state != DONE) && full)
                      || ((kind == K_OP) && !take_a && !swap_op)
                      || ((kind == K_ENTER) && !take_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENTER_A;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (do_esc) begin
            state_d = ENTER_A;
        end else if (take_a) begin
            state_d = ENTER_B;
        end else if (take_b) begin
            state_d = DONE;
        end else if (do_restart) begin
            state_d = ENTER_A;
        end
    end

    always_comb begin
        buffer_d    = buffer;
        cnt_d       = digit_cnt;
        operand_a_d = operand_a;
        operand_b_d = operand_b;
        op_d        = op;
        go_d        = take_b;
        err_d       = reject;
        if (do_esc) begin
            buffer_d    = '0;
            cnt_d       = '0;
            operand_a_d = '0;
            operand_b_d = '0;
            op_d        = 2'd0;
        end else if (do_bksp) begin
            buffer_d = buffer >> 4;
            cnt_d    = digit_cnt - 1'b1;
        end else if (do_shift) begin
            buffer_d = (buffer << 4) | BW'(digit_val(code));
            cnt_d    = digit_cnt + 1'b1;
        end else if (do_restart) begin
            buffer_d = BW'(digit_val(code));
            cnt_d    = CW'(1);
        end else if (take_a) begin
            operand_a_d = buffer;
            op_d        = op_val(code);
            buffer_d    = '0;
            cnt_d       = '0;
        end else if (swap_op) begin
            op_d = op_val(code);
        end else if (take_b) begin
            operand_b_d = buffer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buffer    <= '0;
            digit_cnt <= '0;
            operand_a <= '0;
            operand_b <= '0;
            op        <= 2'd0;
            go        <= 1'b0;
            err       <= 1'b0;
        end else begin
            buffer    <= buffer_d;
            digit_cnt <= cnt_d;
            operand_a <= operand_a_d;
            operand_b <= operand_b_d;
            op        <= op_d;
            go        <= go_d;
            err       <= err_d;
        end
    end

    assign disp_bcd = buffer;
    assign phase    = state;

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: directed scenarios plus random key streams
// checked against a digit-queue model of the expression entry rules.
module tb_keypad_operand_entry;

    localparam int DIGITS = 4;
    localparam int SCAN_W = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [8:0]  last_change = '0;
    logic [15:0] disp_bcd, operand_a, operand_b;
    logic [2:0]  digit_cnt;
    logic [1:0]  op, phase;
    logic        go, err;

    always #5 clk = ~clk;

    keypad_operand_entry #(.DIGITS(DIGITS), .SCAN_W(SCAN_W)) dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .last_change(last_change),
        .disp_bcd(disp_bcd), .digit_cnt(digit_cnt), .operand_a(operand_a),
        .operand_b(operand_b), .op(op), .phase(phase), .go(go), .err(err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: the buffer is a queue of entered digits, oldest first.
    int     dq[$];
    int     m_phase;
    longint m_a, m_b;
    int     m_op;
    bit     m_go, m_err;
    int     digit_codes[10] = '{'h070, 'h069, 'h072, 'h07A, 'h06B, 'h073, 'h074, 'h06C, 'h075, 'h07D};
    int     op_codes[3]     = '{'h079, 'h07B, 'h03A};

    function automatic longint m_val();
        longint v = 0;
        foreach (dq[i]) v = v * 16 + dq[i];
        return v;
    endfunction

    function automatic void m_reset();
        dq.delete();
        m_phase = 0; m_a = 0; m_b = 0; m_op = 0; m_go = 0; m_err = 0;
    endfunction

    function automatic void m_apply(int code);
        int d = -1;
        int o = -1;
        m_go = 0; m_err = 0;
        for (int i = 0; i < 10; i++) if (digit_codes[i] == code) d = i;
        for (int i = 0; i < 3; i++) if (op_codes[i] == code) o = i;
        if (code == 'h076) begin
            m_reset();
        end else if (code == 'h066) begin
            if (dq.size() > 0) void'(dq.pop_back());
        end else if (d >= 0) begin
            if (m_phase == 2) begin
                dq.delete(); dq.push_back(d); m_phase = 0;
            end else if (dq.size() < DIGITS) dq.push_back(d);
            else m_err = 1;
        end else if (o >= 0) begin
            if (m_phase == 0 && dq.size() >= 1) begin
                m_a = m_val(); m_op = o; dq.delete(); m_phase = 1;
            end else if (m_phase == 1 && dq.size() == 0) m_op = o;
            else m_err = 1;
        end else if (code == 'h15A || code == 'h05A) begin
            if (m_phase == 1 && dq.size() >= 1) begin
                m_b = m_val(); m_go = 1; m_phase = 2;
            end else m_err = 1;
        end
    endfunction

    // Called at a falling edge; returns at the next falling edge with the key applied.
    task automatic drive_key(int code);
        key_valid = 1'b1;
        last_change = 9'(code);
        m_apply(code);
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(int n);
        repeat (n) begin
            m_go = 0; m_err = 0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (disp_bcd !== 16'h0) begin n_bad++; $display("FAIL reset_disp: got %h want 0000", disp_bcd); end
        n_cmp++; if (digit_cnt !== 3'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", digit_cnt); end
        n_cmp++; if ({operand_a, operand_b} !== 32'h0) begin n_bad++; $display("FAIL reset_operands: got %h/%h want 0", operand_a, operand_b); end
        n_cmp++; if ({op, phase, go, err} !== 6'b0) begin n_bad++; $display("FAIL reset_ctrl: op %0d phase %0d go %b err %b want all 0", op, phase, go, err); end
    endtask

    task automatic test_digit_entry();
        int keys[3] = '{'h069, 'h072, 'h07A};
        foreach (keys[i]) begin
            drive_key(keys[i]);
            n_cmp++; if ({go, err} !== 2'b00) begin n_bad++; $display("FAIL entry_pulse%0d: go %b err %b want 0 0", i, go, err); end
        end
        n_cmp++; if (disp_bcd !== 16'h0123) begin n_bad++; $display("FAIL entry_disp: got %h want 0123", disp_bcd); end
        n_cmp++; if (digit_cnt !== 3'd3) begin n_bad++; $display("FAIL entry_cnt: got %0d want 3", digit_cnt); end
        n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL entry_phase: got %0d want 0", phase); end
    endtask

    task automatic test_expression();
        drive_key('h076);
        drive_key('h069); drive_key('h072); drive_key('h079);
        n_cmp++; if (operand_a !== 16'h0012) begin n_bad++; $display("FAIL expr_operand_a: got %h want 0012", operand_a); end
        n_cmp++; if (op !== 2'd0) begin n_bad++; $display("FAIL expr_op: got %0d want 0", op); end
        n_cmp++; if (disp_bcd !== 16'h0) begin n_bad++; $display("FAIL expr_disp_clear: got %h want 0000", disp_bcd); end
        n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL expr_phase_b: got %0d want 1", phase); end
        drive_key('h075); drive_key('h15A);
        n_cmp++; if (operand_b !== 16'h0008) begin n_bad++; $display("FAIL expr_operand_b: got %h want 0008", operand_b); end
        n_cmp++; if ({go, err} !== 2'b10) begin n_bad++; $display("FAIL expr_go: go %b err %b want 1 0", go, err); end
        n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL expr_phase_done: got %0d want 2", phase); end
        n_cmp++; if (disp_bcd !== 16'h0008) begin n_bad++; $display("FAIL expr_disp_kept: got %h want 0008", disp_bcd); end
        idle(1);
        n_cmp++; if (go !== 1'b0) begin n_bad++; $display("FAIL expr_go_width: got %b want 0", go); end
    endtask

    task automatic test_overflow_edit();
        drive_key('h076);
        for (int i = 1; i <= 5; i++) begin
            drive_key(digit_codes[i]);
            n_cmp++; if (err !== (i == 5)) begin n_bad++; $display("FAIL ovf_err%0d: got %b want %b", i, err, (i == 5)); end
        end
        n_cmp++; if (disp_bcd !== 16'h1234) begin n_bad++; $display("FAIL ovf_disp: got %h want 1234", disp_bcd); end
        drive_key('h066);
        n_cmp++; if (disp_bcd !== 16'h0123 || digit_cnt !== 3'd3) begin n_bad++; $display("FAIL bksp_one: got %h cnt %0d want 0123 cnt 3", disp_bcd, digit_cnt); end
        for (int i = 0; i < 4; i++) begin
            drive_key('h066);
            n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL bksp_err%0d: got %b want 0", i, err); end
        end
        n_cmp++; if (disp_bcd !== 16'h0 || digit_cnt !== 3'd0) begin n_bad++; $display("FAIL bksp_empty: got %h cnt %0d want 0000 cnt 0", disp_bcd, digit_cnt); end
    endtask

    task automatic test_illegal();
        drive_key('h076);
        drive_key('h079);
        n_cmp++; if ({err, phase} !== 3'b100) begin n_bad++; $display("FAIL ill_op_empty: err %b phase %0d want 1 0", err, phase); end
        drive_key('h06B); drive_key('h079);
        drive_key('h07B);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL ill_swap_sub_err: got %b want 0", err); end
        drive_key('h03A);
        n_cmp++; if (op !== 2'd2 || err !== 1'b0) begin n_bad++; $display("FAIL ill_swap_mul: op %0d err %b want 2 0", op, err); end
        drive_key('h05A);
        n_cmp++; if (err !== 1'b1 || phase !== 2'd1) begin n_bad++; $display("FAIL ill_enter_empty: err %b phase %0d want 1 1", err, phase); end
        drive_key('h073); drive_key('h079);
        n_cmp++; if (err !== 1'b1 || op !== 2'd2) begin n_bad++; $display("FAIL ill_op_with_digits: err %b op %0d want 1 2", err, op); end
    endtask

    task automatic test_escape_reset();
        drive_key('h076);
        drive_key('h072); drive_key('h07B); drive_key('h074);
        drive_key('h076);
        n_cmp++; if ({disp_bcd, operand_a, operand_b, digit_cnt, op, phase} !== '0) begin
            n_bad++; $display("FAIL esc_clear: disp %h a %h b %h cnt %0d op %0d phase %0d want all 0",
                              disp_bcd, operand_a, operand_b, digit_cnt, op, phase);
        end
        drive_key('h069); drive_key('h07D);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({disp_bcd, digit_cnt, phase} !== '0) begin n_bad++; $display("FAIL async_reset: disp %h cnt %0d phase %0d want 0", disp_bcd, digit_cnt, phase); end
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ignored();
        drive_key('h069); drive_key('h01C);
        n_cmp++; if (err !== 1'b0 || disp_bcd !== 16'(m_val()) || digit_cnt !== 3'(dq.size())) begin
            n_bad++; $display("FAIL ign_junk: err %b disp %h cnt %0d want 0 %h %0d", err, disp_bcd, digit_cnt, 16'(m_val()), dq.size());
        end
        last_change = 9'h070;
        idle(10);
        n_cmp++; if (disp_bcd !== 16'h0001 || digit_cnt !== 3'd1 || err !== 1'b0) begin
            n_bad++; $display("FAIL ign_held: disp %h cnt %0d err %b want 0001 1 0", disp_bcd, digit_cnt, err);
        end
    endtask

    task automatic test_random();
        drive_key('h076);
        for (int i = 0; i < 600; i++) begin
            int r = $urandom_range(0, 99);
            int code = 0;
            if (r < 45)      code = digit_codes[$urandom_range(0, 9)];
            else if (r < 60) code = op_codes[$urandom_range(0, 2)];
            else if (r < 70) code = ($urandom_range(0, 1) != 0) ? 'h15A : 'h05A;
            else if (r < 80) code = 'h066;
            else if (r < 82) code = 'h076;
            else if (r < 90) code = $urandom_range(0, 511);
            if (r < 90) drive_key(code);
            else begin
                last_change = 9'($urandom);
                idle(1);
            end
            n_cmp++; if (disp_bcd !== 16'(m_val()) || digit_cnt !== 3'(dq.size())) begin
                n_bad++; $display("FAIL rnd_buffer@%0d: disp %h cnt %0d want %h %0d", i, disp_bcd, digit_cnt, 16'(m_val()), dq.size());
            end
            n_cmp++; if (operand_a !== 16'(m_a) || operand_b !== 16'(m_b) || op !== 2'(m_op)) begin
                n_bad++; $display("FAIL rnd_operands@%0d: a %h b %h op %0d want %h %h %0d", i, operand_a, operand_b, op, 16'(m_a), 16'(m_b), m_op);
            end
            n_cmp++; if (phase !== 2'(m_phase) || go !== m_go || err !== m_err) begin
                n_bad++; $display("FAIL rnd_ctrl@%0d: phase %0d go %b err %b want %0d %b %b", i, phase, go, err, m_phase, m_go, m_err);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_digit_entry();
        test_expression();
        test_overflow_edit();
        test_illegal();
        test_escape_reset();
        test_ignored();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
